// File: rtl/rs_int.sv
// rs_int: integer reservation station, a data-capture scheduler that sits ahead of integer execute.
// Optional feature macro RS_AGE_SELECT_EN:
//   defined   -> oldest-ready-first select, tracked by an entry age matrix
//   undefined -> fixed priority, the lowest-index ready entry wins

package rs_int_pkg;
  localparam int ROB_W  = 6;
  localparam int PREG_W = 7;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {OP_NONE, OP_REG, OP_IMM} t_optype;

  typedef struct packed {
    logic [7:0] opcode;
    t_optype    src1_type;
    t_optype    src2_type;
  } t_uinstr;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    t_uinstr             uinstr;
    logic [ROB_W-1:0]    robid;
    logic [PREG_W-1:0]   pdst;
    logic [PREG_W-1:0]   psrc1;
    logic                psrc1_rdy;
    logic [DATA_W-1:0]   src1_val;
    logic [PREG_W-1:0]   psrc2;
    logic                psrc2_rdy;
    logic [DATA_W-1:0]   src2_val;
  } t_rs_disp_pkt;

  typedef struct packed {
    logic [PREG_W-1:0] pdst;
    logic [DATA_W-1:0] data;
  } t_prf_wr_pkt;

  typedef struct packed {
    t_uinstr           uinstr;
    logic [ROB_W-1:0]  robid;
    logic [PREG_W-1:0] pdst;
    logic [DATA_W-1:0] src1_val;
    logic [DATA_W-1:0] src2_val;
  } t_iss_pkt;
endpackage

// One scheduler slot: holds the uop and snoops the write-back bus for its missing sources.
module rs_int_entry
  import rs_int_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc,
  input  logic                         kill,
  input  t_rs_disp_pkt                 disp_pkt,
  input  logic                         wr_en,
  input  t_prf_wr_pkt                  wr_pkt,
  output logic                         valid,
  output logic                         ready,
  output t_iss_pkt                     pkt,
  output logic [1:0]                   src_rdy,
  output logic [1:0][PREG_W-1:0]       src_psrc
);
  logic                   valid_q;
  t_uinstr                uinstr_q;
  logic [ROB_W-1:0]       robid_q;
  logic [PREG_W-1:0]      pdst_q;
  logic [1:0]             rdy_q;
  logic [1:0][PREG_W-1:0] psrc_q;
  logic [1:0][DATA_W-1:0] val_q;

  logic [1:0]             in_rdy;
  logic [1:0][PREG_W-1:0] in_psrc;
  logic [1:0][DATA_W-1:0] in_val;
  logic [1:0]             wake_in;
  logic [1:0]             wake;

  assign in_rdy  = {disp_pkt.psrc2_rdy, disp_pkt.psrc1_rdy};
  assign in_psrc = {disp_pkt.psrc2, disp_pkt.psrc1};
  assign in_val  = {disp_pkt.src2_val, disp_pkt.src1_val};

  // wake_in catches a write-back coincident with dispatch so it is not lost
  for (genvar s = 0; s < 2; s++) begin : g_src
    assign wake_in[s] = wr_en & ~in_rdy[s] & (in_psrc[s] == wr_pkt.pdst);
    assign wake[s]    = wr_en & valid_q & ~rdy_q[s] & (psrc_q[s] == wr_pkt.pdst);
  end

  // slot state: kill beats alloc beats wakeup
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      uinstr_q <= '0;
      robid_q  <= '0;
      pdst_q   <= '0;
      rdy_q    <= '0;
      psrc_q   <= '0;
      val_q    <= '0;
    end else if (kill) begin
      valid_q <= 1'b0;
    end else if (alloc) begin
      valid_q  <= 1'b1;
      uinstr_q <= disp_pkt.uinstr;
      robid_q  <= disp_pkt.robid;
      pdst_q   <= disp_pkt.pdst;
      psrc_q   <= in_psrc;
      for (int s = 0; s < 2; s++) begin
        rdy_q[s] <= in_rdy[s] | wake_in[s];
        val_q[s] <= wake_in[s] ? wr_pkt.data : in_val[s];
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wake[s]) begin
          rdy_q[s] <= 1'b1;
          val_q[s] <= wr_pkt.data;
        end
      end
    end
  end

  assign valid    = valid_q;
  assign ready    = valid_q & (&rdy_q);
  assign src_rdy  = rdy_q;
  assign src_psrc = psrc_q;
  assign pkt      = '{uinstr: uinstr_q, robid: robid_q, pdst: pdst_q,
                      src1_val: val_q[0], src2_val: val_q[1]};
endmodule

module rs_int
  import rs_int_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  t_nuke_pkt                    nuke_rb1,
  input  logic                         disp_valid_rs0,
  input  t_rs_disp_pkt                 disp_pkt_rs0,
  output logic                         disp_stall_rs0,
  input  logic                         iprf_wr_en_ex1,
  input  t_prf_wr_pkt                  iprf_wr_pkt_ex1,
  output logic                         iss_ex0,
  output t_iss_pkt                     iss_pkt_ex0,
  output logic [$clog2(NUM_ENTRIES):0] occupancy
);
  localparam int            CW   = $clog2(NUM_ENTRIES) + 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_ENTRIES);

  logic [CW-1:0]                          occ_q;
  logic [NUM_ENTRIES-1:0]                 ent_valid, ent_ready, alloc_oh, sel_oh, kill;
  t_iss_pkt                               ent_pkt [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0][1:0]            ent_rdy;
  logic [NUM_ENTRIES-1:0][1:0][PREG_W-1:0] ent_psrc;
  logic                                   nuke, full, accept, issue;

  // stall comes from registered occupancy only, so a same-cycle issue never frees credit
  assign nuke   = nuke_rb1.valid;
  assign full   = (occ_q == FULL);
  assign accept = reset & disp_valid_rs0 & ~full & ~nuke;
  assign issue  = reset & ~nuke & (|sel_oh);

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
    assign kill[i] = nuke | (issue & sel_oh[i]);
    rs_int_entry u_ent (
      .clk      (clk),
      .reset    (reset),
      .alloc    (accept & alloc_oh[i]),
      .kill     (kill[i]),
      .disp_pkt (disp_pkt_rs0),
      .wr_en    (iprf_wr_en_ex1),
      .wr_pkt   (iprf_wr_pkt_ex1),
      .valid    (ent_valid[i]),
      .ready    (ent_ready[i]),
      .pkt      (ent_pkt[i]),
      .src_rdy  (ent_rdy[i]),
      .src_psrc (ent_psrc[i])
    );
  end

  // lowest-index free slot receives the dispatch
  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!ent_valid[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  // age_q[i][j]=1: entry i is older than entry j
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q;

  // oldest ready entry: ready with no older ready entry
  always_comb begin
    logic older_rdy;
    older_rdy = 1'b0;
    sel_oh    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      older_rdy = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && ent_ready[j] && age_q[j][i]) older_rdy = 1'b1;
      end
      sel_oh[i] = ent_ready[i] & ~older_rdy;
    end
  end

  // new entry is younger than every currently valid entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      age_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (alloc_oh[i]) begin
          age_q[i] <= '0;
          for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (j != i) age_q[j][i] <= ent_valid[j];
          end
        end
      end
    end
  end
`else
  // fixed priority: lowest ready index wins
  always_comb begin
    logic found;
    found  = 1'b0;
    sel_oh = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_ready[i] && !found) begin
        sel_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

  // issue mux, zero when nothing issues
  always_comb begin
    iss_pkt_ex0 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (issue && sel_oh[i]) iss_pkt_ex0 = ent_pkt[i];
    end
  end

  // occupancy counter, cleared by nuke
  always_ff @(posedge clk) begin
    if (!reset)    occ_q <= '0;
    else if (nuke) occ_q <= '0;
    else           occ_q <= occ_q + CW'(accept) - CW'(issue);
  end

  assign iss_ex0        = issue;
  assign disp_stall_rs0 = reset & full;
  assign occupancy      = reset ? occ_q : '0;

`ifndef SYNTHESIS
  logic                   wb_seen_q;
  logic [PREG_W-1:0]      wb_pdst_q;
  logic [NUM_ENTRIES-1:0] stale;

  // remember last write-back so we can confirm nobody missed it
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_seen_q <= 1'b0;
      wb_pdst_q <= '0;
    end else begin
      wb_seen_q <= iprf_wr_en_ex1;
      wb_pdst_q <= iprf_wr_pkt_ex1.pdst;
    end
  end

  // any valid entry still waiting on the register just written
  always_comb begin
    stale = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (wb_seen_q && ent_valid[i] && !ent_rdy[i][s] && ent_psrc[i][s] == wb_pdst_q)
          stale[i] = 1'b1;
      end
    end
  end

  a_one_issue: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(sel_oh & {NUM_ENTRIES{issue}}));
  a_no_disp_stalled: assert property (@(posedge clk) disable iff (!reset)
    !(disp_valid_rs0 && full))
    else $warning("rs_int: dispatch while stalled was dropped");
  a_no_missed_wake: assert property (@(posedge clk) disable iff (!reset)
    stale == '0);
`endif
endmodule

// File: tb/tb_rs_int.sv
// tb_rs_int: directed bench for rs_int with a slot/sequence-number reference model.
module tb_rs_int;
  import rs_int_pkg::*;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  t_nuke_pkt     nuke_rb1;
  logic          disp_valid_rs0;
  t_rs_disp_pkt  disp_pkt_rs0;
  logic          disp_stall_rs0;
  logic          iprf_wr_en_ex1;
  t_prf_wr_pkt   iprf_wr_pkt_ex1;
  logic          iss_ex0;
  t_iss_pkt      iss_pkt_ex0;
  logic [$clog2(N):0] occupancy;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: slot contents plus a dispatch sequence number for age
  bit                m_v    [N];
  int unsigned       m_seq  [N];
  int unsigned       seq_ctr = 0;
  t_uinstr           m_ui   [N];
  logic [ROB_W-1:0]  m_rob  [N];
  logic [PREG_W-1:0] m_pdst [N];
  logic [PREG_W-1:0] m_ps   [N][2];
  bit                m_rdy  [N][2];
  logic [DATA_W-1:0] m_val  [N][2];

  rs_int #(.NUM_ENTRIES(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .nuke_rb1        (nuke_rb1),
    .disp_valid_rs0  (disp_valid_rs0),
    .disp_pkt_rs0    (disp_pkt_rs0),
    .disp_stall_rs0  (disp_stall_rs0),
    .iprf_wr_en_ex1  (iprf_wr_en_ex1),
    .iprf_wr_pkt_ex1 (iprf_wr_pkt_ex1),
    .iss_ex0         (iss_ex0),
    .iss_pkt_ex0     (iss_pkt_ex0),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic t_rs_disp_pkt mk(input logic [ROB_W-1:0] robid, input logic [PREG_W-1:0] pdst,
                                      input logic [PREG_W-1:0] ps1, input logic r1, input logic [DATA_W-1:0] v1,
                                      input logic [PREG_W-1:0] ps2, input logic r2, input logic [DATA_W-1:0] v2);
    t_rs_disp_pkt p;
    p = '0;
    p.uinstr.opcode    = 8'h01;
    p.uinstr.src1_type = OP_REG;
    p.uinstr.src2_type = OP_REG;
    p.robid = robid; p.pdst = pdst;
    p.psrc1 = ps1; p.psrc1_rdy = r1; p.src1_val = v1;
    p.psrc2 = ps2; p.psrc2_rdy = r2; p.src2_val = v2;
    return p;
  endfunction

  task automatic idle();
    nuke_rb1        = '0;
    disp_valid_rs0  = 1'b0;
    disp_pkt_rs0    = '0;
    iprf_wr_en_ex1  = 1'b0;
    iprf_wr_pkt_ex1 = '0;
  endtask

  // compare this cycle's outputs with the model, then advance the model across the edge
  task automatic check_cycle();
    int occ, win, slot;
    bit exp_stall;
    t_iss_pkt exp_pkt;
    logic [PREG_W-1:0] dps [2];
    bit                drd [2];
    logic [DATA_W-1:0] dvl [2];
    if (!reset) begin
      chk("rst_iss", 128'(iss_ex0), 128'(0));
      chk("rst_pkt", 128'(iss_pkt_ex0), 128'(0));
      chk("rst_stall", 128'(disp_stall_rs0), 128'(0));
      chk("rst_occ", 128'(occupancy), 128'(0));
      for (int i = 0; i < N; i++) m_v[i] = 0;
      return;
    end
    occ = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) occ++;
    exp_stall = (occ == N);
    win = -1;
    if (!nuke_rb1.valid) begin
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && m_rdy[i][0] && m_rdy[i][1]) begin
`ifdef RS_AGE_SELECT_EN
          if (win < 0 || m_seq[i] < m_seq[win]) win = i;
`else
          if (win < 0) win = i;
`endif
        end
      end
    end
    chk("iss_vld", 128'(iss_ex0), 128'(win >= 0));
    chk("stall", 128'(disp_stall_rs0), 128'(exp_stall));
    chk("occ", 128'(occupancy), 128'(occ));
    if (win >= 0) begin
      exp_pkt.uinstr = m_ui[win]; exp_pkt.robid = m_rob[win]; exp_pkt.pdst = m_pdst[win];
      exp_pkt.src1_val = m_val[win][0]; exp_pkt.src2_val = m_val[win][1];
      chk("iss_pkt", 128'(iss_pkt_ex0), 128'(exp_pkt));
    end
    if (nuke_rb1.valid) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      return;
    end
    slot = -1;
    for (int i = 0; i < N; i++) if (!m_v[i] && slot < 0) slot = i;
    if (win >= 0) m_v[win] = 0;
    if (iprf_wr_en_ex1) begin
      for (int i = 0; i < N; i++)
        for (int s = 0; s < 2; s++)
          if (m_v[i] && !m_rdy[i][s] && m_ps[i][s] == iprf_wr_pkt_ex1.pdst) begin
            m_rdy[i][s] = 1; m_val[i][s] = iprf_wr_pkt_ex1.data;
          end
    end
    if (disp_valid_rs0 && !exp_stall) begin
      dps[0] = disp_pkt_rs0.psrc1; drd[0] = disp_pkt_rs0.psrc1_rdy; dvl[0] = disp_pkt_rs0.src1_val;
      dps[1] = disp_pkt_rs0.psrc2; drd[1] = disp_pkt_rs0.psrc2_rdy; dvl[1] = disp_pkt_rs0.src2_val;
      m_v[slot] = 1; m_seq[slot] = seq_ctr++;
      m_ui[slot] = disp_pkt_rs0.uinstr; m_rob[slot] = disp_pkt_rs0.robid; m_pdst[slot] = disp_pkt_rs0.pdst;
      for (int s = 0; s < 2; s++) begin
        m_ps[slot][s] = dps[s]; m_rdy[slot][s] = drd[s]; m_val[slot][s] = dvl[s];
        if (iprf_wr_en_ex1 && !drd[s] && dps[s] == iprf_wr_pkt_ex1.pdst) begin
          m_rdy[slot][s] = 1; m_val[slot][s] = iprf_wr_pkt_ex1.data;
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin sample(); nxt(); end
  endtask

  task automatic wb(input logic [PREG_W-1:0] p, input logic [DATA_W-1:0] d);
    iprf_wr_en_ex1 = 1'b1;
    iprf_wr_pkt_ex1.pdst = p;
    iprf_wr_pkt_ex1.data = d;
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // 1: reset dominates a live dispatch, then a ready ADD issues one cycle after dispatch
    for (int k = 0; k < 2; k++) begin
      disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(9, 1, 2, 1, 32'h11, 3, 1, 32'h22);
      sample(); nxt();
    end
    reset = 1'b1;
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(3, 4, 5, 1, 32'h5, 6, 1, 32'h6);
    sample(); chk("t1_same_cycle", 128'(iss_ex0), 128'(0)); nxt();
    sample(); chk("t1_iss", 128'(iss_ex0), 128'(1)); chk("t1_robid", 128'(iss_pkt_ex0.robid), 128'(3));
    chk("t1_occ", 128'(occupancy), 128'(1)); nxt();
    run(1);

    // 2: producer/dependent with one bubble
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(4, 10, 1, 1, 32'h5, 2, 1, 32'h6);
    sample(); nxt();
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(5, 11, 10, 0, 32'h0, 2, 1, 32'h7);
    sample(); chk("t2_prod_robid", 128'(iss_pkt_ex0.robid), 128'(4)); nxt();
    wb(10, 32'h1234);
    sample(); chk("t2_bubble", 128'(iss_ex0), 128'(0)); nxt();
    sample(); chk("t2_dep_iss", 128'(iss_ex0), 128'(1));
    chk("t2_src1", 128'(iss_pkt_ex0.src1_val), 128'(32'h1234)); nxt();
    run(1);

    // 3: write-back coincident with dispatch is captured
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(6, 12, 1, 1, 32'h1, 7, 0, 32'h0);
    wb(7, 32'hABCD);
    sample(); nxt();
    sample(); chk("t3_iss", 128'(iss_ex0), 128'(1));
    chk("t3_src2", 128'(iss_pkt_ex0.src2_val), 128'(32'hABCD)); nxt();

    // 4: fill, stall, drop extra dispatch, stall releases the cycle after issue
    for (int i = 0; i < N; i++) begin
      disp_valid_rs0 = 1'b1;
      disp_pkt_rs0 = mk(ROB_W'(10 + i), PREG_W'(20 + i), PREG_W'(40 + i), 0, 32'h0, 0, 1, 32'h9);
      sample(); nxt();
    end
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(20, 30, 1, 1, 32'h1, 2, 1, 32'h2);
    sample(); chk("t4_stall", 128'(disp_stall_rs0), 128'(1)); chk("t4_occ8", 128'(occupancy), 128'(8)); nxt();
    wb(43, 32'h4343);
    sample(); chk("t4_occ_kept", 128'(occupancy), 128'(8)); nxt();
    sample(); chk("t4_robid13", 128'(iss_pkt_ex0.robid), 128'(13));
    chk("t4_stall_hold", 128'(disp_stall_rs0), 128'(1)); nxt();
    sample(); chk("t4_unstall", 128'(disp_stall_rs0), 128'(0)); chk("t4_occ7", 128'(occupancy), 128'(7)); nxt();
    for (int p = 40; p < 48; p++) begin
      if (p != 43) begin wb(PREG_W'(p), DATA_W'(p)); sample(); nxt(); end
    end
    run(3);

    // 5: nuke with 5 valid entries, one ready, and a simultaneous dispatch
    for (int i = 0; i < 4; i++) begin
      disp_valid_rs0 = 1'b1;
      disp_pkt_rs0 = mk(ROB_W'(30 + i), PREG_W'(60 + i), PREG_W'(50 + i), 0, 32'h0, 0, 1, 32'h3);
      sample(); nxt();
    end
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(34, 64, 1, 1, 32'h1, 2, 1, 32'h2);
    sample(); nxt();
    nuke_rb1.valid = 1'b1;
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(35, 65, 1, 1, 32'h1, 2, 1, 32'h2);
    wb(50, 32'h5050);
    sample(); chk("t5_nuke_iss", 128'(iss_ex0), 128'(0)); chk("t5_occ5", 128'(occupancy), 128'(5)); nxt();
    sample(); chk("t5_occ0", 128'(occupancy), 128'(0)); nxt();
    for (int p = 50; p < 54; p++) begin
      wb(PREG_W'(p), 32'h77);
      sample(); chk("t5_no_flushed_iss", 128'(iss_ex0), 128'(0)); nxt();
    end
    run(2);

    // 6: select policy with a reused low slot
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(1, 70, 1, 1, 32'h1, 2, 1, 32'h2);
    sample(); nxt();
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(2, 71, 80, 0, 32'h0, 2, 1, 32'h2);
    sample(); chk("t6_r1", 128'(iss_pkt_ex0.robid), 128'(1)); nxt();
    disp_valid_rs0 = 1'b1; disp_pkt_rs0 = mk(3, 72, 80, 0, 32'h0, 2, 1, 32'h2);
    sample(); nxt();
    wb(80, 32'h8080);
    sample(); nxt();
`ifdef RS_AGE_SELECT_EN
    sample(); chk("t6_first", 128'(iss_pkt_ex0.robid), 128'(2)); nxt();
    sample(); chk("t6_second", 128'(iss_pkt_ex0.robid), 128'(3)); nxt();
`else
    sample(); chk("t6_first", 128'(iss_pkt_ex0.robid), 128'(3)); nxt();
    sample(); chk("t6_second", 128'(iss_pkt_ex0.robid), 128'(2)); nxt();
`endif
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_int.md
Name: rs_int

Overview:
- Integer reservation station: data-capture scheduler directly upstream of the integer execute stage.
- Accepts renamed uops from dispatch and holds them until both source operands are available.
- Captures operand data from the EX1 PRF write-back broadcast.
- Selects one ready uop per cycle and drives iss_ex0/iss_pkt_ex0 into execute.

Parameters:
NUM_ENTRIES, 8, number of scheduler entries (power of 2, ≥2)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-low: state resets on a rising clk edge while reset==0
nuke_rb1  input  t_nuke_pkt  pipeline flush from ROB; .valid flushes every entry
disp_valid_rs0  input  1  dispatch request
disp_pkt_rs0  input  t_rs_disp_pkt  uinstr, robid, pdst, psrc1/psrc1_rdy/src1_val, psrc2/psrc2_rdy/src2_val
disp_stall_rs0  output  1  station full; dispatch must not be asserted
iprf_wr_en_ex1  input  1  execute write-back valid (wakeup)
iprf_wr_pkt_ex1  input  t_prf_wr_pkt  write-back pdst/data
iss_ex0  output  1  issue valid to execute
iss_pkt_ex0  output  t_iss_pkt  issued uop: uinstr, robid, pdst, src1_val, src2_val
occupancy  output  $clog2(NUM_ENTRIES)+1  valid entry count

Behaviour:
- Reset (reset==0 at posedge): all entries invalid, age state cleared.
  - Same cycle: iss_ex0=0, iss_pkt_ex0='0, disp_stall_rs0=0, occupancy=0.
  - Reset overrides dispatch, wakeup and nuke.
- Entry contents: valid, uinstr, robid, pdst, per source {psrc, rdy, val}.
  - Sources whose optype != OP_REG arrive with rdy=1 and are never woken.
- Dispatch:
  - When disp_valid_rs0 && !disp_stall_rs0, the packet is written into the lowest-index free entry at the clock edge.
  - disp_stall_rs0 = (occupancy == NUM_ENTRIES), derived from registered state only; same-cycle issue does not free credit.
  - Dispatch while stalled is dropped (assertion).
- Wakeup:
  - Each cycle with iprf_wr_en_ex1, every valid entry source with rdy==0 and psrc==iprf_wr_pkt_ex1.pdst sets rdy=1 and val=data.
  - The same compare applies to the dispatching packet's non-ready sources, so a write-back coincident with dispatch is captured, not lost.
- Select:
  - Combinational over registered entry state: ready = valid & src1.rdy & src2.rdy.
  - The winner per the select policy (see Optional Feature) drives iss_ex0=1 and iss_pkt_ex0 from its entry, including captured values.
  - The issued entry is invalidated at the edge.
  - An entry dispatched in cycle T issues no earlier than T+1.
- Latency:
  - Producer issued at T writes back at T+1 (EX1); dependent wakes at T+1 edge and issues at T+2 (one bubble).
  - A wakeup in cycle T never makes an entry issue in cycle T (value captured into the register first).
- Nuke:
  - nuke_rb1.valid in cycle T forces iss_ex0=0 in T and invalidates all entries at the edge.
  - Nuke wins over dispatch and wakeup in the same cycle; occupancy=0 in T+1.
- Occupancy:
  - Registered; next = cur + dispatch_accepted − issued, or 0 on nuke.
  - Range 0..NUM_ENTRIES; no wrap.
- Assertions:
  - At most one entry issued per cycle.
  - No dispatch while stalled.
  - No entry with rdy==0 matches a psrc of an OP_REG source already written this cycle after the edge.

Optional Feature:
- Macro RS_AGE_SELECT_EN.
- Defined:
  - Oldest-first select via an NUM_ENTRIES×NUM_ENTRIES age matrix; age[i][j]=1 means i older than j.
  - On dispatch into i: row i cleared, column i set for all valid j.
  - Winner = ready entry with no older ready entry.
- Undefined:
  - Fixed priority, lowest ready index wins.
  - No age storage.
  - Functionally correct but may starve high indices.

Test Plan:
1. Reset low 2 cycles with disp_valid_rs0=1 → occupancy=0, iss_ex0=0, iss_pkt_ex0=0 throughout; after reset=1, dispatch of an all-ready ADD (robid 3) → iss_ex0=1 next cycle with robid 3.
2. Dispatch producer (pdst 10, ready) at T0, dependent (psrc1=10, not ready) at T1 → producer issues T1, write-back pdst 10 data 0x1234 at T2, dependent issues T3 with src1_val=0x1234.
3. Write-back pdst 7 data 0xABCD in the same cycle as dispatch of an uop with psrc2=7 not ready → uop issues next cycle with src2_val=0xABCD.
4. Fill 8 non-ready entries → disp_stall_rs0=1, occupancy=8; extra dispatch ignored; one wakeup then issue → stall drops the cycle after issue.
5. Nuke with 5 valid entries, a ready entry, and a simultaneous dispatch → iss_ex0=0 that cycle, occupancy=0 next, no later issue of any flushed robid.
6. RS_AGE_SELECT_EN: dispatch robids 1→entry0, 2→entry1, free entry0 via issue, dispatch 3→entry0, wake 2 and 3 together → robid 2 issues first. Without the macro → robid 3 issues first.
